// File: rtl/vga_text_scanner.sv
// Snapshots NUM_CH channels and writes "II: HHHH" text fields into a VGA character buffer.
// Optional macro VGA_SCAN_DIFF_EN: highlight (w_data[7]) value digits of channels that changed since last scan.
module vga_text_scanner #(
  parameter int NUM_CH         = 32,
  parameter int DATA_W         = 32,
  parameter int COLS           = 80,
  parameter int ROWS           = 30,
  parameter int BASE_ROW       = 2,
  parameter int CH_PER_ROW     = 4,
  parameter int FIELD_W        = 20,
  parameter int ADDR_W         = 12,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     wen,
  input  logic                     w_ready,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [7:0]               w_data
);

  // state | meaning
  // IDLE  | waiting for start or refresh tick
  // SNAP  | capture ch_data, reset field counters
  // EMIT  | present one character per cycle, advance on w_ready
  // DONE  | one-cycle completion pulse

  localparam int NIBS      = DATA_W / 4;
  localparam int FIELD_CH  = 4 + NIBS;
  localparam int CI_W      = $clog2(FIELD_CH);
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CR_W      = (CH_PER_ROW > 1) ? $clog2(CH_PER_ROW) : 1;
  localparam int USED_ROWS = (NUM_CH + CH_PER_ROW - 1) / CH_PER_ROW;

  if (DATA_W % 4 != 0) begin : g_err_data_w
    $error("vga_text_scanner: DATA_W must be a multiple of 4");
  end
  if (FIELD_W < FIELD_CH) begin : g_err_field_w
    $error("vga_text_scanner: FIELD_W too small for the field text");
  end
  if (BASE_ROW + USED_ROWS > ROWS) begin : g_err_rows
    $error("vga_text_scanner: fields do not fit in ROWS");
  end
  if (NUM_CH < 1 || NUM_CH > 256) begin : g_err_num_ch
    $error("vga_text_scanner: NUM_CH must be 1..256");
  end

  typedef enum logic [1:0] {IDLE, SNAP, EMIT, DONE} state_t;

  state_t            state, next;
  logic              pending;
  logic              tick;
  logic              req;
  logic [7:0]        ch_idx;
  logic [CI_W-1:0]   char_idx;
  logic [CR_W-1:0]   ch_in_row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_base;
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] cur;
  logic [CI_W-1:0]   pos;
  logic [3:0]        nib;
  logic [7:0]        ch_char;
  logic              value_char;
  logic              hl;
  logic              last_char;
  logic              last_ch;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  if (REFRESH_CYCLES > 0) begin : g_refresh
    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [RC_W-1:0] rcnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rcnt <= '0;
      else if (rcnt == RC_W'(REFRESH_CYCLES - 1)) rcnt <= '0;
      else rcnt <= rcnt + 1'b1;
    end
    assign tick = (rcnt == RC_W'(REFRESH_CYCLES - 1));
  end else begin : g_no_refresh
    assign tick = 1'b0;
  end

  // A simultaneous start and tick collapse into one request here.
  assign req       = start | tick;
  assign last_char = (char_idx == CI_W'(FIELD_CH - 1));
  assign last_ch   = (ch_idx == 8'(NUM_CH - 1));

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (req) next = SNAP;
      SNAP:    next = EMIT;
      EMIT:    if (w_ready && last_char && last_ch) next = DONE;
      DONE:    next = (pending || req) ? SNAP : IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      ch_idx    <= '0;
      char_idx  <= '0;
      ch_in_row <= '0;
      row_base  <= '0;
      col_base  <= '0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      state <= next;
      if (state == DONE) pending <= 1'b0;
      else if (state != IDLE && req) pending <= 1'b1;
      case (state)
        SNAP: begin
          for (int i = 0; i < NUM_CH; i++) snap[i] <= ch_data[i*DATA_W +: DATA_W];
          ch_idx    <= '0;
          char_idx  <= '0;
          ch_in_row <= '0;
          col_base  <= '0;
          row_base  <= ADDR_W'(BASE_ROW * COLS);
        end
        EMIT: begin
          if (w_ready && !(last_char && last_ch)) begin
            if (!last_char) begin
              char_idx <= char_idx + 1'b1;
            end else begin
              char_idx <= '0;
              ch_idx   <= ch_idx + 8'd1;
              // Row/column bases stepped incrementally instead of multiplying.
              if (ch_in_row == CR_W'(CH_PER_ROW - 1)) begin
                ch_in_row <= '0;
                col_base  <= '0;
                row_base  <= row_base + ADDR_W'(COLS);
              end else begin
                ch_in_row <= ch_in_row + 1'b1;
                col_base  <= col_base + ADDR_W'(FIELD_W);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sel        = ch_idx[SEL_W-1:0];
  assign cur        = snap[sel];
  assign pos        = CI_W'(NIBS + 3) - char_idx;
  assign nib        = 4'(cur >> {pos, 2'b00});
  assign value_char = (char_idx >= CI_W'(4));

  always_comb begin
    ch_char = 8'h00;
    if (char_idx == CI_W'(0))      ch_char = hex_char(ch_idx[7:4]);
    else if (char_idx == CI_W'(1)) ch_char = hex_char(ch_idx[3:0]);
    else if (char_idx == CI_W'(2)) ch_char = 8'h3A;
    else if (char_idx == CI_W'(3)) ch_char = 8'h20;
    else                           ch_char = hex_char(nib);
  end

`ifdef VGA_SCAN_DIFF_EN
  logic [DATA_W-1:0] prev [NUM_CH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) prev[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < NUM_CH; i++) prev[i] <= snap[i];
    end
  end
  assign hl = value_char && (cur != prev[sel]);
`else
  assign hl = 1'b0;
`endif

  assign busy   = (state == SNAP) || (state == EMIT);
  assign done   = (state == DONE);
  assign wen    = (state == EMIT);
  assign w_addr = wen ? (row_base + col_base + ADDR_W'(char_idx)) : '0;
  assign w_data = wen ? (ch_char | {hl, 7'b0}) : 8'h00;

endmodule

// File: doc/vga_text_scanner.md
Name: vga_text_scanner

Overview:
- Parametrised successor to the fixed-register VGA debug path.
- Snapshots NUM_CH generic DATA_W-bit channels and renders each as a text field "II: HHHH…" (hex index, colon, space, hex value).
- Writes one character per accepted cycle into the VGA character buffer through the wen/w_addr/w_data write port of the display block.
- Supports on-demand and periodic refresh, with ready backpressure on the write port.

Parameters:
- NUM_CH, 32, number of channels (1..256).
- DATA_W, 32, bits per channel; must be a multiple of 4.
- COLS, 80, text columns per screen row.
- ROWS, 30, text rows per screen.
- BASE_ROW, 2, first screen row used for fields.
- CH_PER_ROW, 4, fields per screen row.
- FIELD_W, 20, columns per field; must be >= 4 + DATA_W/4.
- ADDR_W, 12, width of w_addr.
- REFRESH_CYCLES, 0, auto-refresh period in cycles; 0 disables auto-refresh.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: asynchronous active-low reset.
- ch_data, input, NUM_CH*DATA_W: packed channels; channel i occupies bits [i*DATA_W +: DATA_W].
- start, input, 1: refresh request pulse.
- busy, output, 1: high from the snapshot cycle through the last write.
- done, output, 1: one-cycle pulse after the last character is accepted.
- wen, output, 1: character write valid.
- w_ready, input, 1: display buffer accepts a write when wen & w_ready.
- w_addr, output, ADDR_W: character cell address = row*COLS + col.
- w_data, output, 8: ASCII code; bit 7 reserved for highlight.

Behaviour:
- Reset (rst=0, asynchronous) forces all outputs, state, and counters to 0 and the FSM to IDLE.
  - If reset arrives mid-scan, wen drops immediately and the scan is abandoned.
  - No done pulse is generated for an abandoned scan.
- FSM states:
  - IDLE: waits for start=1 or an auto tick → SNAP.
  - SNAP: one cycle. Copies all of ch_data into snapshot registers and clears ch_idx and char_idx. Sets busy=1 → EMIT.
  - EMIT: presents wen=1 with the current character.
    - The character advances only on wen & w_ready. Address and data stay stable while w_ready=0.
    - After the last character of the last channel is accepted → DONE.
  - DONE: one cycle with done=1 and busy=0 → IDLE.
- Field layout for channel i:
  - row = BASE_ROW + i / CH_PER_ROW.
  - col = (i % CH_PER_ROW) * FIELD_W.
  - The field holds 4 + DATA_W/4 chars in this order:
    - hex(i[7:4]), hex(i[3:0]), ':' (0x3A), ' ' (0x20),
    - then DATA_W/4 nibbles of the snapshot, MSB first.
  - Remaining field columns are never written.
  - Hex digits are uppercase: 0-9 → 0x30-0x39, A-F → 0x41-0x46.
  - Characters of one channel go to consecutive addresses; channels are emitted in order 0..NUM_CH-1.
- Addressing:
  - Compute addresses incrementally (a row-base register plus a column counter); no runtime multiplier.
  - w_addr is truncated to ADDR_W bits; wrap-around is the integrator's responsibility.
- Total accepted writes per scan = NUM_CH*(4+DATA_W/4).
- Latency: with w_ready tied high, start sampled at cycle 0 gives:
  - SNAP at cycle 1;
  - first wen at cycle 2;
  - last write at cycle 1+NUM_CH*(4+DATA_W/4);
  - done one cycle later.
- Snapshot isolation: changes on ch_data during EMIT do not affect the scan in progress.
- start while busy:
  - Sets a single pending flag; further starts while pending are merged.
  - On leaving DONE with the flag set, the FSM goes straight to SNAP and clears the flag.
- Auto-refresh (REFRESH_CYCLES>0):
  - A free-running counter counts 0..REFRESH_CYCLES-1 and produces a tick at wrap.
  - A tick behaves exactly like start, including the pending merge.
  - If start and a tick occur in the same cycle, they count as one request.
- Elaboration errors: DATA_W%4≠0, FIELD_W<4+DATA_W/4, or rows exceeding ROWS.

Optional Feature:
- Macro: VGA_SCAN_DIFF_EN.
- Defined:
  - A second register bank holds the previous snapshot (reset 0).
  - In EMIT, the value-nibble characters of any channel whose snapshot differs from the previous one are written with w_data[7]=1 (highlight).
  - Index, ':' and ' ' characters are never highlighted.
  - The previous bank is updated from the snapshot in DONE.
- Undefined: w_data[7] is always 0 and the previous bank is not instantiated.

Test Plan:
- NUM_CH=2, DATA_W=8, FIELD_W=8, CH_PER_ROW=1, BASE_ROW=2, COLS=80, w_ready=1; ch0=0xA5, ch1=0x3C; start → 12 writes:
  - 0x30,0x30,0x3A,0x20,0x41,0x35 at addr 160..165;
  - 0x30,0x31,0x3A,0x20,0x33,0x43 at addr 240..245;
  - done exactly 1 cycle after the last write.
- Defaults, w_ready toggled 1/0 every cycle → 384 accepted writes; w_addr/w_data are held whenever w_ready=0; done follows the 384th acceptance.
- ch_data changed every cycle during EMIT → emitted digits equal the values present in the SNAP cycle.
- start pulsed 3 times during a scan → exactly one extra scan follows; done pulses twice in total.
- rst=0 asserted mid-EMIT → wen, busy and done are 0 at once; a later start yields a full scan starting at channel 0.
- VGA_SCAN_DIFF_EN defined, two scans with only ch5 changed (0x0 → 0x1234) → in the second scan, only ch5's 8 value characters have bit7=1.
